// File: rtl/usb2_vendreq_pkg.sv
// Shared request codes and FSM encoding for the EP0 vendor-request decoder.
package usb2_vendreq_pkg;

  localparam logic [7:0] REQ_WRITE_BASE = 8'h10;
  localparam logic [7:0] REQ_SELECT     = 8'h21;
  localparam logic [7:0] REQ_SETBITS    = 8'h22;
  localparam logic [7:0] REQ_CLRBITS    = 8'h23;
  localparam logic [7:0] REQ_PULSE      = 8'h30;
  localparam logic [7:0] REQ_CLRERR     = 8'h3F;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StPulse  = 2'd2
  } vend_state_e;

endpackage

// File: rtl/usb2_vendreq_pulse.sv
// Timed one-hot pulse generator: a pulse of width+1 cycles on output idx after load.
module usb2_vendreq_pulse
  import usb2_vendreq_pkg::*;
#(
  parameter int unsigned NPULSE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [2:0]        idx,
  input  logic [7:0]        width,
  output logic [NPULSE-1:0] pulse,
  output logic              done
);

  logic [7:0] cnt;
  logic       running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 8'd0;
      running <= 1'b0;
      pulse   <= '0;
    end else if (load) begin
      cnt     <= width;
      running <= 1'b1;
      for (int i = 0; i < NPULSE; i++) begin
        pulse[i] <= (idx == 3'(i));
      end
    end else if (running) begin
      // Counter reaching zero is the last high cycle; drop together with the FSM exit.
      if (cnt == 8'd0) begin
        running <= 1'b0;
        pulse   <= '0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  assign done = running && (cnt == 8'd0);

endmodule

// File: rtl/usb2_ep0_vendreq.sv
// EP0 vendor-request decoder: register bank, bit set/clear, timed pulses, status flags.
module usb2_ep0_vendreq
  import usb2_vendreq_pkg::*;
#(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned NPULSE = 8
) (
  input  logic                  phy_clk,
  input  logic                  reset_n,
  input  logic                  vend_req_act,
  input  logic [7:0]            vend_req_request,
  input  logic [15:0]           vend_req_val,
  output logic [NREGS*16-1:0]   reg_out,
  output logic                  reg_wr_strobe,
  output logic [3:0]            reg_wr_addr,
  output logic [NPULSE-1:0]     pulse_out,
  output logic                  busy,
  output logic                  err_overrun,
  output logic                  err_unknown,
  output logic [7:0]            req_count
);

  localparam logic [4:0] NREGS_W  = 5'(NREGS);
  localparam logic [3:0] NPULSE_W = 4'(NPULSE);

  vend_state_e state;
  logic        act_d;
  logic        act_edge;
  logic [7:0]  act_req;
  logic [15:0] act_val;
  logic        pend_vld;
  logic [7:0]  pend_req;
  logic [15:0] pend_val;
  logic [3:0]  sel;
  logic [15:0] regs [NREGS];

  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [15:0] wr_data;
  logic [15:0] sel_val;
  logic        sel_ok;
  logic        op_select;
  logic        op_pulse;
  logic        op_clrerr;
  logic        op_bad;
  logic        pulse_load;
  logic        pulse_done;

  assign act_edge = vend_req_act & ~act_d;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_out[16*i +: 16] = regs[i];
    end
  end

  // Decode of the active request; only acted upon in StDecode.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel == 4'(i)) sel_val = regs[i];
    end
    sel_ok    = ({1'b0, sel} < NREGS_W);
    wr_en     = 1'b0;
    wr_idx    = sel;
    wr_data   = act_val;
    op_select = 1'b0;
    op_pulse  = 1'b0;
    op_clrerr = 1'b0;
    op_bad    = 1'b0;
    if (act_req[7:4] == REQ_WRITE_BASE[7:4]) begin
      wr_idx = act_req[3:0];
      if ({1'b0, act_req[3:0]} < NREGS_W) wr_en = 1'b1;
      else op_bad = 1'b1;
    end else begin
      case (act_req)
        REQ_SELECT:  op_select = 1'b1;
        REQ_SETBITS: begin
          if (sel_ok) begin
            wr_en   = 1'b1;
            wr_data = sel_val | act_val;
          end else begin
            op_bad = 1'b1;
          end
        end
        REQ_CLRBITS: begin
          if (sel_ok) begin
            wr_en   = 1'b1;
            wr_data = sel_val & ~act_val;
          end else begin
            op_bad = 1'b1;
          end
        end
        REQ_PULSE: begin
          if ({1'b0, act_val[2:0]} < NPULSE_W) op_pulse = 1'b1;
          else op_bad = 1'b1;
        end
        REQ_CLRERR:  op_clrerr = 1'b1;
        default:     op_bad = 1'b1;
      endcase
    end
  end

  assign pulse_load = (state == StDecode) && op_pulse;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == StDecode && wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_idx == 4'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StIdle;
      act_d         <= 1'b0;
      act_req       <= 8'd0;
      act_val       <= 16'd0;
      pend_vld      <= 1'b0;
      pend_req      <= 8'd0;
      pend_val      <= 16'd0;
      sel           <= 4'd0;
      busy          <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= 4'd0;
      err_overrun   <= 1'b0;
      err_unknown   <= 1'b0;
      req_count     <= 8'd0;
    end else begin
      act_d         <= vend_req_act;
      reg_wr_strobe <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pend_vld) begin
            act_req  <= pend_req;
            act_val  <= pend_val;
            pend_vld <= act_edge;
            if (act_edge) begin
              pend_req <= vend_req_request;
              pend_val <= vend_req_val;
            end
            state <= StDecode;
            busy  <= 1'b1;
          end else if (act_edge) begin
            act_req <= vend_req_request;
            act_val <= vend_req_val;
            state   <= StDecode;
            busy    <= 1'b1;
          end
        end
        StDecode: begin
          req_count <= req_count + 8'd1;
          if (wr_en) begin
            reg_wr_strobe <= 1'b1;
            reg_wr_addr   <= wr_idx;
          end
          if (op_select) sel <= act_val[3:0];
          if (op_clrerr) begin
            err_overrun <= 1'b0;
            err_unknown <= 1'b0;
          end
          if (op_bad) err_unknown <= 1'b1;
          if (op_pulse) begin
            state <= StPulse;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StPulse: begin
          if (pulse_done) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
      // Late assignment so a fresh overrun beats a CLRERR in the same cycle.
      if (act_edge && state != StIdle) begin
        if (pend_vld) begin
          err_overrun <= 1'b1;
        end else begin
          pend_vld <= 1'b1;
          pend_req <= vend_req_request;
          pend_val <= vend_req_val;
        end
      end
    end
  end

  usb2_vendreq_pulse #(
    .NPULSE (NPULSE)
  ) u_pulse (
    .clk   (phy_clk),
    .rst_n (reset_n),
    .load  (pulse_load),
    .idx   (act_val[2:0]),
    .width (act_val[15:8]),
    .pulse (pulse_out),
    .done  (pulse_done)
  );

endmodule

// File: tb/tb_usb2_ep0_vendreq.sv
// Scoreboard bench for usb2_ep0_vendreq (NREGS=8, NPULSE=8).
`timescale 1ns/1ps
module tb_usb2_ep0_vendreq;

  localparam int unsigned NREGS  = 8;
  localparam int unsigned NPULSE = 8;

  logic                phy_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                vend_req_act = 1'b0;
  logic [7:0]          vend_req_request = 8'h00;
  logic [15:0]         vend_req_val = 16'h0000;
  logic [NREGS*16-1:0] reg_out;
  logic                reg_wr_strobe;
  logic [3:0]          reg_wr_addr;
  logic [NPULSE-1:0]   pulse_out;
  logic                busy;
  logic                err_overrun;
  logic                err_unknown;
  logic [7:0]          req_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobe = 0;
  logic [19:0] exp_q [$];

  usb2_ep0_vendreq #(
    .NREGS  (NREGS),
    .NPULSE (NPULSE)
  ) dut (
    .phy_clk          (phy_clk),
    .reset_n          (reset_n),
    .vend_req_act     (vend_req_act),
    .vend_req_request (vend_req_request),
    .vend_req_val     (vend_req_val),
    .reg_out          (reg_out),
    .reg_wr_strobe    (reg_wr_strobe),
    .reg_wr_addr      (reg_wr_addr),
    .pulse_out        (pulse_out),
    .busy             (busy),
    .err_overrun      (err_overrun),
    .err_unknown      (err_unknown),
    .req_count        (req_count)
  );

  always #5 phy_clk = ~phy_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input int i);
    return reg_out[16*i +: 16];
  endfunction

  // Each register strobe must match the oldest expected {addr, data}.
  always @(negedge phy_clk) begin
    if (reset_n && reg_wr_strobe) begin
      logic [19:0] e;
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("sb_strobe_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", 32'(reg_wr_addr), 32'(e[19:16]));
        check("sb_data", 32'(rd(int'(e[19:16]))), 32'(e[15:0]));
      end
    end
  end

  task automatic send(input logic [7:0] r, input logic [15:0] v, input int hold);
    @(negedge phy_clk);
    vend_req_act = 1'b1;
    vend_req_request = r;
    vend_req_val = v;
    repeat (hold) @(negedge phy_clk);
    vend_req_act = 1'b0;
    vend_req_request = 8'h00;
    vend_req_val = 16'h0000;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge phy_clk);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cyc;
    int pulse_cyc;
    int stray;
    int strobes0;

    repeat (3) @(negedge phy_clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_regs_zero", 32'(reg_out == '0), 32'd1);
    check("rst_count", 32'(req_count), 32'd0);
    check("rst_errs", 32'({err_overrun, err_unknown}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge phy_clk);

    // Long-held WRITE counts once; operands after the edge are ignored.
    @(negedge phy_clk);
    vend_req_act = 1'b1; vend_req_request = 8'h13; vend_req_val = 16'hBEEF;
    exp_q.push_back({4'd3, 16'hBEEF});
    @(posedge phy_clk); #1;
    check("wr_busy_T1", 32'(busy), 32'd1);
    check("wr_nostrobe_T1", 32'(reg_wr_strobe), 32'd0);
    @(negedge phy_clk);
    vend_req_request = 8'h55; vend_req_val = 16'h0000;
    @(posedge phy_clk); #1;
    check("wr_strobe_T2", 32'(reg_wr_strobe), 32'd1);
    check("wr_addr_T2", 32'(reg_wr_addr), 32'd3);
    check("wr_reg3_T2", 32'(rd(3)), 32'hBEEF);
    @(posedge phy_clk); #1;
    check("wr_strobe_once", 32'(reg_wr_strobe), 32'd0);
    repeat (2) @(negedge phy_clk);
    vend_req_act = 1'b0;
    wait_idle("wr", 50);
    check("wr_one_strobe", 32'(n_strobe), 32'd1);
    check("wr_count", 32'(req_count), 32'd1);

    // SELECT / SETBITS / CLRBITS on reg 2.
    send(8'h21, 16'h0002, 1); wait_idle("sel", 50);
    exp_q.push_back({4'd2, 16'h0F00});
    send(8'h12, 16'h0F00, 1); wait_idle("wr2", 50);
    exp_q.push_back({4'd2, 16'h0FF0});
    send(8'h22, 16'h00F0, 1); wait_idle("setb", 50);
    check("setbits_reg2", 32'(rd(2)), 32'h0FF0);
    exp_q.push_back({4'd2, 16'h0EF0});
    send(8'h23, 16'h0100, 2); wait_idle("clrb", 50);
    check("clrbits_reg2", 32'(rd(2)), 32'h0EF0);
    check("bits_strobes", 32'(n_strobe), 32'd4);
    check("bits_count", 32'(req_count), 32'd5);

    // PULSE index 5, width 4+1.
    @(negedge phy_clk);
    vend_req_act = 1'b1; vend_req_request = 8'h30; vend_req_val = 16'h0405;
    @(posedge phy_clk); #1;
    check("pulse_busy_T1", 32'(busy), 32'd1);
    check("pulse_low_T1", 32'(pulse_out), 32'd0);
    busy_cyc = 1; pulse_cyc = 0; stray = 0;
    @(negedge phy_clk);
    vend_req_act = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge phy_clk); #1;
      if (k == 1) check("pulse_on_T2", 32'(pulse_out), 32'h20);
      if (busy) busy_cyc++;
      if (pulse_out[5]) pulse_cyc++;
      if ((pulse_out & 8'hDF) != 8'h00) stray++;
    end
    check("pulse_width", 32'(pulse_cyc), 32'd5);
    check("pulse_busy_len", 32'(busy_cyc), 32'd6);
    check("pulse_other_bits", 32'(stray), 32'd0);
    check("pulse_count", 32'(req_count), 32'd6);

    // Long pulse with two queued writes: one pends, one overruns.
    strobes0 = n_strobe;
    send(8'h30, 16'hFF00, 1);
    repeat (10) @(negedge phy_clk);
    exp_q.push_back({4'd4, 16'h1111});
    send(8'h14, 16'h1111, 2);
    repeat (3) @(negedge phy_clk);
    send(8'h15, 16'h2222, 2);
    repeat (2) @(negedge phy_clk);
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_pulse0", 32'(pulse_out), 32'h01);
    check("ovr_flag", 32'(err_overrun), 32'd1);
    check("ovr_reg4_waits", 32'(rd(4)), 32'h0000);
    wait_idle("ovr", 600);
    check("ovr_reg4", 32'(rd(4)), 32'h1111);
    check("ovr_reg5_dropped", 32'(rd(5)), 32'h0000);
    check("ovr_strobes", 32'(n_strobe - strobes0), 32'd1);
    check("ovr_count", 32'(req_count), 32'd8);
    send(8'h3F, 16'h0000, 1); wait_idle("clrerr", 50);
    check("clrerr_ovr", 32'(err_overrun), 32'd0);
    check("clrerr_count", 32'(req_count), 32'd9);

    // Unknown code and out-of-range WRITE index.
    strobes0 = n_strobe;
    send(8'h55, 16'h1234, 1); wait_idle("unk", 50);
    check("unk_flag", 32'(err_unknown), 32'd1);
    send(8'h1F, 16'h5678, 1); wait_idle("oor", 50);
    check("oor_flag", 32'(err_unknown), 32'd1);
    check("oor_no_strobe", 32'(n_strobe - strobes0), 32'd0);
    check("oor_count", 32'(req_count), 32'd11);
    check("oor_ovr_clear", 32'(err_overrun), 32'd0);

    // Reset in the middle of a pulse with a write pending.
    send(8'h30, 16'h1003, 1);
    repeat (3) @(negedge phy_clk);
    send(8'h16, 16'h6666, 1);
    repeat (2) @(negedge phy_clk);
    check("mid_pulse_on", 32'(pulse_out), 32'h08);
    #3 reset_n = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_regs_zero", 32'(reg_out == '0), 32'd1);
    check("arst_count", 32'(req_count), 32'd0);
    check("arst_errs", 32'({err_overrun, err_unknown}), 32'd0);
    repeat (2) @(negedge phy_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge phy_clk);
    exp_q.push_back({4'd1, 16'hABCD});
    send(8'h11, 16'hABCD, 1); wait_idle("post_rst", 50);
    check("post_rst_reg1", 32'(rd(1)), 32'hABCD);
    check("post_rst_reg6", 32'(rd(6)), 32'h0000);
    check("post_rst_count", 32'(req_count), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb2_ep0_vendreq.md
Name: usb2_ep0_vendreq

Overview:
Consumer of the EP0 vendor-request strobe bus (vend_req_act / vend_req_request / vend_req_val), directly downstream of the EP0 control endpoint.
- Decodes vendor request codes into a bank of 16-bit control registers, bit set/clear operations and timed output pulses.
- Provides application logic with register contents, write strobes and error/status flags.
- Same phy_clk domain as EP0; no CDC inside.

Parameters:
NREGS, 16, number of 16-bit control registers (1..16)
NPULSE, 8, number of pulse outputs (1..8)

Ports:
phy_clk  input  1  clock (same as EP0)
reset_n  input  1  reset; asynchronous, active-low
vend_req_act  input  1  request strobe from EP0, high >=1 cycle per request
vend_req_request  input  8  bRequest, valid while vend_req_act high
vend_req_val  input  16  wValue, valid while vend_req_act high
reg_out  output  NREGS*16  flattened register bank, reg i at [16i+15:16i]
reg_wr_strobe  output  1  one-cycle pulse on any register modification
reg_wr_addr  output  4  index of register modified, valid with strobe
pulse_out  output  NPULSE  timed pulse outputs
busy  output  1  FSM not in IDLE
err_overrun  output  1  sticky: request dropped, pending slot full
err_unknown  output  1  sticky: unknown code or out-of-range index
req_count  output  8  accepted-request counter, wraps 255->0

Behaviour:
- Reset values (async on reset_n low): all regs 0, reg_wr_strobe 0, reg_wr_addr 0, pulse_out 0, busy 0, err_* 0, req_count 0, sel 0, pending empty, state IDLE, act_d 0.
- Edge detect: act_d <= vend_req_act. An edge is vend_req_act & ~act_d. request/val are captured on the edge cycle only. A long-held act counts as one request.
- Request codes (wValue = V):
  - 0x10..0x1F WRITE: reg[req[3:0]] <= V.
  - 0x21 SELECT: sel <= V[3:0]; no register write, no strobe.
  - 0x22 SETBITS: reg[sel] <= reg[sel] | V.
  - 0x23 CLRBITS: reg[sel] <= reg[sel] & ~V.
  - 0x30 PULSE: pulse_out[V[2:0]] high for V[15:8]+1 cycles (1..256).
  - 0x3F CLRERR: err_overrun, err_unknown <= 0.
  - Any other code, register index >= NREGS, or pulse index >= NPULSE: err_unknown <= 1, no other effect; still counts in req_count.
- FSM states: IDLE, DECODE, PULSE.
  - IDLE: if pending valid, load active <= pending, clear pending, go to DECODE. Else, on an edge, load active <= inputs, go to DECODE.
  - DECODE (1 cycle): execute the op, req_count++, then go to PULSE for a valid pulse op, else to IDLE.
  - PULSE: pulse counter loaded with V[15:8] on DECODE exit; pulse_out bit high every PULSE cycle; decrement each cycle; leave to IDLE in the cycle the counter equals 0.
- Latency: edge seen at cycle T -> busy high at T+1 -> register value, reg_wr_strobe and reg_wr_addr visible at T+2 (strobe exactly one cycle) -> pulse_out high from T+2.
- Pending slot (depth 1):
  - An edge while state != IDLE is stored in pending.
  - An edge in the IDLE cycle that consumes pending is also stored in pending.
  - An edge while pending is already full is dropped and sets err_overrun.
- CLRERR and a new error in the same DECODE: the error wins (set has priority).
- Width rules: SETBITS/CLRBITS on sel >= NREGS flag err_unknown. req_count wraps modulo 256.
- Reset mid-pulse: pulse_out drops immediately (async), pending discarded.

Decomposition:
- Package usb2_vendreq_pkg: request code constants (REQ_WRITE_BASE 0x10, REQ_SELECT 0x21, REQ_SETBITS 0x22, REQ_CLRBITS 0x23, REQ_PULSE 0x30, REQ_CLRERR 0x3F) and FSM state encodings.
- One sub-module, usb2_vendreq_pulse:
  - Takes load, index and width; drives the NPULSE outputs and a done flag.
  - 8-bit down-counter.

Test Plan:
- act high 4 cycles, req 0x13, V 0xBEEF -> reg[3]=0xBEEF at T+2, one reg_wr_strobe with addr 3, req_count=1.
- SELECT V=2; SETBITS V=0x00F0 on reg[2]=0x0F00; CLRBITS V=0x0100 -> reg[2]=0x0FF0 then 0x0EF0, strobes with addr 2.
- PULSE V=0x0405 -> pulse_out[5] high exactly 5 cycles from T+2, busy high 6 cycles, other bits 0.
- PULSE V=0xFF00, then two WRITE requests during the pulse -> first executes after the pulse, second dropped, err_overrun=1; CLRERR clears it.
- req 0x55, then WRITE 0x1F with NREGS=8 -> err_unknown=1, no strobe, req_count increments by 2.
- reset_n low mid-PULSE -> pulse_out, busy, regs and req_count at 0 immediately; next request is processed normally.
